cpu_control_fsm: RTL and testbench
==================================

# cpu_control_fsm

Multi-cycle control unit for the 16-bit datapath: captures the fetched instruction, decodes it, and sequences register-file, ALU, memory and PC controls through fetch/decode/execute/memory/branch/jump states. Successor to the three-state ALU-only controller. Adds load/store, conditional branch and jump, flag-write control and a parametrised immediate width. Sits between instruction/data memory and the register-file/ALU/PC datapath.

## Interface
- DATA_W, 16, datapath width; `imm` is extended to this width (≥ 8)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  16  memory read data, sampled as instruction at end of FETCH
- flags  in  4  {Z,N,C,F} from flag register
- mem_ack  in  1  memory done (used only with CTRL_FSM_MEMWAIT_EN)
- pc_en  out  1  PC update this cycle
- pc_sel  out  2  00 PC+1, 01 PC+imm, 10 PC←reg[rsrc]
- addr_sel  out  1  memory address: 0 PC, 1 reg[rsrc]
- mem_we  out  1  data memory write
- reg_we  out  1  register-file write
- wb_sel  out  1  write-back source: 0 ALU, 1 memory
- flags_we  out  1  flag register load
- rsrc, rdest  out  4 each  register indices
- r_i  out  1  0 register operand, 1 immediate
- opcode  out  8  ALU opcode
- imm  out  DATA_W  extended immediate

## Operation
- States: FETCH, DECODE, EXEC, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP. Moore outputs from state plus internal `ir_q`.
- FETCH: addr_sel=0, all enables 0; `ir_q` ← instr at exiting edge; → DECODE.
- DECODE: all enables 0; fields valid from `ir_q`; dispatch:
  - IR[15:12]=0000 (R-type): opcode={0000,IR[7:4]}, rdest=IR[11:8], rsrc=IR[3:0], r_i=0 → EXEC.
  - IR[15:12]=0100, IR[7:4]=0000 LOAD (rdest=IR[11:8], rsrc=IR[3:0]) → MEM_RD; 0100 STOR (rdest=data reg IR[11:8], rsrc=addr IR[3:0]) → MEM_WR; 1100 Jcond (cond IR[11:8], rsrc=IR[3:0]) → JUMP; other 0100 extensions → EXEC as NOP.
  - IR[15:12]=1100 Bcond (cond IR[11:8], disp IR[7:0]) → BRANCH.
  - Else I-type: opcode={IR[15:12],IR[11:8]}, rdest=IR[11:8], r_i=1 → EXEC.
- EXEC: pc_en=1, pc_sel=00, flags_we=1 for arithmetic/compare; reg_we=1 except CMP (R ext 1011), CMPI (IR[15:12]=1011) and NOP; → FETCH.
- MEM_RD: addr_sel=1 → MEM_WB. MEM_WB: addr_sel=1, reg_we=1, wb_sel=1, pc_en=1, pc_sel=00 → FETCH.
- MEM_WR: addr_sel=1, mem_we=1, pc_en=1, pc_sel=00 → FETCH.
- BRANCH: pc_en=1, pc_sel=01 if taken else 00 → FETCH. JUMP: pc_en=1, pc_sel=10 if taken else 00 → FETCH.
- Conditions: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 F; 0111 !F; 1110 always; others never.
- Immediate: IR[7:0] zero-extended for ANDI/ORI/XORI (IR[15:12]=0001/0010/0011), sign-extended otherwise (incl. branch disp). R-type/memory: imm=0.

## Timing
- Reset (async): state=FETCH, ir_q=0; outputs take FETCH values (all enables 0, pc_sel=00, addr_sel=0, rsrc=rdest=0, r_i=0, opcode=0, imm=0). Reset mid-instruction aborts it; no write enable asserts after rst rises.
- Latency: ALU/I-type, store, branch, jump 3 cycles; load 4 cycles. Exactly one pc_en pulse per instruction, in the final state.
- Flags sampled combinationally during BRANCH/JUMP.
- Outputs outside listed states are 0; rsrc/rdest/opcode/imm hold decoded values from DECODE to end of instruction.

## Configuration
- CTRL_FSM_MEMWAIT_EN defined: MEM_RD and MEM_WR hold (mem_we stays 1 in MEM_WR; pc_en 0 until ack) until mem_ack=1; MEM_WR asserts pc_en only in the ack cycle; MEM_RD advances to MEM_WB on ack.
- Undefined: mem_ack ignored; memory states last one cycle each.

## Test plan
- ADD r3,r2 (0x0352) after reset -> FETCH,DECODE,EXEC; EXEC: reg_we=1, rdest=3, rsrc=2, opcode=0x05, r_i=0, one pc_en.
- CMPI r1,#-1 (0xB1FF) -> EXEC: reg_we=0, flags_we=1, imm=0xFFFF; ANDI r1,#0xFF (0x11FF) -> imm=0x00FF, reg_we=1.
- LOAD r4,[r6] (0x4406) -> 4 cycles; MEM_WB: reg_we=1, wb_sel=1, rdest=4, addr_sel=1; STOR (0x4546) -> MEM_WR mem_we=1, rsrc=6.
- BEQ disp=-2 (0xC0FE) with Z=1 -> pc_sel=01, imm=0xFFFE; Z=0 -> pc_sel=00; JUC r7 (0x4EC7) -> pc_sel=10, rsrc=7.
- rst asserted during MEM_WB -> outputs immediately FETCH values, no reg_we; next fetch resumes normally.
- With CTRL_FSM_MEMWAIT_EN, mem_ack low 3 cycles during STOR -> mem_we high 4 cycles, single pc_en on ack cycle.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute sequencer for the 16-bit datapath.
// Define CTRL_FSM_MEMWAIT_EN to stall MEM_RD/MEM_WR until mem_ack.
module cpu_control_fsm #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       instr,
   input  logic [3:0]        flags,
   input  logic              mem_ack,
   output logic              pc_en,
   output logic [1:0]        pc_sel,
   output logic              addr_sel,
   output logic              mem_we,
   output logic              reg_we,
   output logic              wb_sel,
   output logic              flags_we,
   output logic [3:0]        rsrc,
   output logic [3:0]        rdest,
   output logic              r_i,
   output logic [7:0]        opcode,
   output logic [DATA_W-1:0] imm
);
   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM_RD = 3'd3;
   localparam logic [2:0] MEM_WB = 3'd4;
   localparam logic [2:0] MEM_WR = 3'd5;
   localparam logic [2:0] BRANCH = 3'd6;
   localparam logic [2:0] JUMP   = 3'd7;

   logic [2:0]  state, next;
   logic [15:0] ir_q;
   logic [3:0]  op4, ext, cond, code;
   logic        is_r, is_m, is_b, is_i, is_cmp, arith, active, fsel, taken, ack;

`ifdef CTRL_FSM_MEMWAIT_EN
   assign ack = mem_ack;
`else
   logic unused_ack;
   assign unused_ack = mem_ack;
   assign ack = 1'b1;
`endif

   assign op4    = ir_q[15:12];
   assign cond   = ir_q[11:8];
   assign ext    = ir_q[7:4];
   assign is_r   = op4 == 4'h0;
   assign is_m   = op4 == 4'h4;
   assign is_b   = op4 == 4'hC;
   assign is_i   = !(is_r || is_m || is_b);
   assign is_cmp = (is_r && ext == 4'hB) || op4 == 4'hB;
   // add/sub family and compares update flags; logic ops and moves do not
   assign code   = is_r ? ext : op4;
   assign arith  = (is_r || is_i) && (code inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB});
   assign fsel   = cond[2:1] == 2'd0 ? flags[3] : cond[2:1] == 2'd1 ? flags[1] :
                   cond[2:1] == 2'd2 ? flags[2] : flags[0];
   assign taken  = cond == 4'hE ? 1'b1 : cond[3] ? 1'b0 : fsel ^ cond[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
         ir_q  <= '0;
      end else begin
         state <= next;
         if (state == FETCH) ir_q <= instr;
      end
   end

   always_comb begin
      next = FETCH;
      case (state)
         FETCH:  next = DECODE;
         DECODE: next = is_b ? BRANCH : !is_m ? EXEC : ext == 4'h0 ? MEM_RD :
                        ext == 4'h4 ? MEM_WR : ext == 4'hC ? JUMP : EXEC;
         MEM_RD: next = ack ? MEM_WB : MEM_RD;
         MEM_WR: next = ack ? FETCH : MEM_WR;
         default: next = FETCH;
      endcase
   end

   assign pc_en    = (state inside {EXEC, MEM_WB, BRANCH, JUMP}) || (state == MEM_WR && ack);
   assign pc_sel   = (state == BRANCH && taken) ? 2'b01 : (state == JUMP && taken) ? 2'b10 : 2'b00;
   assign addr_sel = state inside {MEM_RD, MEM_WB, MEM_WR};
   assign mem_we   = state == MEM_WR;
   assign reg_we   = state == MEM_WB || (state == EXEC && !is_m && !is_cmp);
   assign wb_sel   = state == MEM_WB;
   assign flags_we = state == EXEC && arith;

   // decoded fields are live from DECODE to the end of the instruction
   assign active = state != FETCH;
   assign rsrc   = active && (is_r || is_m) ? ir_q[3:0] : 4'h0;
   assign rdest  = active && !is_b ? ir_q[11:8] : 4'h0;
   assign r_i    = active && is_i;
   assign opcode = !active ? 8'h00 : is_r ? {4'h0, ext} : is_i ? {op4, cond} : 8'h00;
   assign imm    = !active || is_r || is_m ? '0 :
                   (is_i && op4 inside {4'h1, 4'h2, 4'h3}) ? DATA_W'(ir_q[7:0]) :
                   DATA_W'($signed(ir_q[7:0]));
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed checks of the control FSM sequencing and decoded fields.
module tb_cpu_control_fsm;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] instr = 16'h0;
   logic [3:0]  flags = 4'h0;
   logic        mem_ack = 1'b1;
   logic        pc_en, addr_sel, mem_we, reg_we, wb_sel, flags_we, r_i;
   logic [1:0]  pc_sel;
   logic [3:0]  rsrc, rdest;
   logic [7:0]  opcode;
   logic [15:0] imm;
   logic [8:0]  ctl;
   logic [31:0] fld;
   int checks = 0;
   int errors = 0;

   cpu_control_fsm #(.DATA_W(16)) dut (
      .clk(clk), .rst(rst), .instr(instr), .flags(flags), .mem_ack(mem_ack),
      .pc_en(pc_en), .pc_sel(pc_sel), .addr_sel(addr_sel), .mem_we(mem_we),
      .reg_we(reg_we), .wb_sel(wb_sel), .flags_we(flags_we), .rsrc(rsrc),
      .rdest(rdest), .r_i(r_i), .opcode(opcode), .imm(imm)
   );

   always #5 clk = ~clk;

   // {pc_en, pc_sel, addr_sel, mem_we, reg_we, wb_sel, flags_we, r_i}
   assign ctl = {pc_en, pc_sel, addr_sel, mem_we, reg_we, wb_sel, flags_we, r_i};
   assign fld = {rsrc, rdest, opcode, imm};

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      checks++;
      if (ctl !== 9'b0 || fld !== 32'h0) begin
         errors++;
         $display("FAIL reset ctl=%b fld=%h exp ctl=0 fld=0", ctl, fld);
      end
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_add;
      int pulses = 0;
      instr = 16'h0352;
      checks++;
      if (ctl !== 9'b0) begin errors++; $display("FAIL add_fetch ctl=%b exp=%b", ctl, 9'b0); end
      step();
      pulses += pc_en;
      checks++;
      if (ctl !== 9'b0 || fld !== 32'h2305_0000) begin
         errors++;
         $display("FAIL add_decode ctl=%b fld=%h exp ctl=0 fld=23050000", ctl, fld);
      end
      step();
      pulses += pc_en;
      checks++;
      if (ctl !== 9'b1_00_0_0_1_0_1_0 || fld !== 32'h2305_0000) begin
         errors++;
         $display("FAIL add_exec ctl=%b fld=%h exp ctl=100001010 fld=23050000", ctl, fld);
      end
      step();
      pulses += pc_en;
      checks++;
      if (pulses != 1 || ctl !== 9'b0) begin
         errors++;
         $display("FAIL add_pc_en pulses=%0d ctl=%b exp pulses=1 ctl=0", pulses, ctl);
      end
   endtask

   task automatic test_imm;
      instr = 16'hB1FF;
      step();
      step();
      checks++;
      if (ctl !== 9'b1_00_0_0_0_0_1_1 || fld !== 32'h01B1_FFFF) begin
         errors++;
         $display("FAIL cmpi_exec ctl=%b fld=%h exp ctl=100000011 fld=01b1ffff", ctl, fld);
      end
      step();
      instr = 16'h11FF;
      step();
      step();
      checks++;
      if (imm !== 16'h00FF || reg_we !== 1'b1 || pc_en !== 1'b1 || r_i !== 1'b1 || opcode !== 8'h11) begin
         errors++;
         $display("FAIL andi_exec imm=%h reg_we=%b pc_en=%b r_i=%b op=%h exp imm=00ff 1 1 1 op=11",
                  imm, reg_we, pc_en, r_i, opcode);
      end
      step();
   endtask

   task automatic test_load;
      instr = 16'h4406;
      step();
      step();
      checks++;
      if (ctl !== 9'b0_00_1_0_0_0_0_0) begin
         errors++;
         $display("FAIL load_rd ctl=%b exp=%b", ctl, 9'b0_00_1_0_0_0_0_0);
      end
      step();
      checks++;
      if (ctl !== 9'b1_00_1_0_1_1_0_0 || rdest !== 4'h4 || rsrc !== 4'h6) begin
         errors++;
         $display("FAIL load_wb ctl=%b rdest=%h rsrc=%h exp ctl=100101100 rdest=4 rsrc=6", ctl, rdest, rsrc);
      end
      step();
      checks++;
      if (ctl !== 9'b0) begin errors++; $display("FAIL load_done ctl=%b exp=0", ctl); end
   endtask

   task automatic test_store;
`ifdef CTRL_FSM_MEMWAIT_EN
      int we_cycles = 0;
      int pulses = 0;
      mem_ack = 1'b0;
      instr = 16'h4546;
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_ack = 1'b1;
         #1;
         we_cycles += mem_we;
         pulses += pc_en;
         checks++;
         if (pc_en !== (i == 3) || rsrc !== 4'h6) begin
            errors++;
            $display("FAIL stor_wait%0d pc_en=%b rsrc=%h exp pc_en=%b rsrc=6", i, pc_en, rsrc, i == 3);
         end
         step();
      end
      checks++;
      if (we_cycles != 4 || pulses != 1 || ctl !== 9'b0) begin
         errors++;
         $display("FAIL stor_wait_sum we=%0d pulses=%0d ctl=%b exp we=4 pulses=1 ctl=0", we_cycles, pulses, ctl);
      end
`else
      mem_ack = 1'b0;
      instr = 16'h4546;
      step();
      step();
      checks++;
      if (ctl !== 9'b1_00_1_1_0_0_0_0 || rsrc !== 4'h6) begin
         errors++;
         $display("FAIL stor_wr ctl=%b rsrc=%h exp ctl=100110000 rsrc=6", ctl, rsrc);
      end
      step();
      checks++;
      if (ctl !== 9'b0) begin errors++; $display("FAIL stor_done ctl=%b exp=0", ctl); end
`endif
      mem_ack = 1'b1;
   endtask

   task automatic test_branch;
      logic [3:0]  fl [3] = '{4'b1000, 4'b0000, 4'b0111};
      logic [1:0]  ex [3] = '{2'b01, 2'b00, 2'b00};
      for (int i = 0; i < 3; i++) begin
         instr = 16'hC0FE;
         flags = fl[i];
         step();
         step();
         checks++;
         if (pc_en !== 1'b1 || pc_sel !== ex[i] || imm !== 16'hFFFE || reg_we !== 1'b0) begin
            errors++;
            $display("FAIL beq%0d pc_en=%b pc_sel=%b imm=%h reg_we=%b exp 1 %b fffe 0",
                     i, pc_en, pc_sel, imm, reg_we, ex[i]);
         end
         step();
      end
      instr = 16'hC1FE;
      flags = 4'b0000;
      step();
      step();
      checks++;
      if (pc_sel !== 2'b01) begin errors++; $display("FAIL bne_taken pc_sel=%b exp=01", pc_sel); end
      step();
   endtask

   task automatic test_jump;
      instr = 16'h4EC7;
      flags = 4'b0000;
      step();
      step();
      checks++;
      if (ctl !== 9'b1_10_0_0_0_0_0_0 || rsrc !== 4'h7) begin
         errors++;
         $display("FAIL juc ctl=%b rsrc=%h exp ctl=110000000 rsrc=7", ctl, rsrc);
      end
      step();
      instr = 16'h4FC7;
      flags = 4'b1111;
      step();
      step();
      checks++;
      if (pc_en !== 1'b1 || pc_sel !== 2'b00) begin
         errors++;
         $display("FAIL jnever pc_en=%b pc_sel=%b exp 1 00", pc_en, pc_sel);
      end
      step();
   endtask

   task automatic test_reset_mid;
      instr = 16'h4406;
      step();
      step();
      step();
      checks++;
      if (reg_we !== 1'b1) begin errors++; $display("FAIL mid_pre reg_we=%b exp=1", reg_we); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (ctl !== 9'b0 || fld !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset ctl=%b fld=%h exp ctl=0 fld=0", ctl, fld);
      end
      step();
      rst = 1'b0;
      instr = 16'h0352;
      step();
      step();
      checks++;
      if (ctl !== 9'b1_00_0_0_1_0_1_0 || fld !== 32'h2305_0000) begin
         errors++;
         $display("FAIL mid_resume ctl=%b fld=%h exp ctl=100001010 fld=23050000", ctl, fld);
      end
      step();
   endtask

   initial begin
      #1;
      test_reset();
      test_add();
      test_imm();
      test_load();
      test_store();
      test_branch();
      test_jump();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
